// File: rtl/vram_pkg.sv
// Shared types and widths for the VRAM responder slice.
package vram_pkg;

  localparam int unsigned VRAM_DATA_W = 16;
  localparam int unsigned VRAM_MASK_W = 4;
  localparam int unsigned NIBBLE_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } vram_resp_state_t;

endpackage

// File: rtl/vram_bram.sv
// Single-port synchronous RAM, 2**ADDR_W x 16, per-nibble write enables and a
// registered read port that only updates when re_i is high.
module vram_bram
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   we_i,
  input  logic                   re_i,
  input  logic [VRAM_MASK_W-1:0] mask_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [VRAM_DATA_W-1:0] wdata_i,
  output logic [VRAM_DATA_W-1:0] rdata_o
);

  logic [VRAM_DATA_W-1:0] mem [2**ADDR_W];
  logic [VRAM_DATA_W-1:0] rdata_q, rdata_d;

  // Nibble-granular write; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned i = 0; i < VRAM_MASK_W; i++) begin
        if (mask_i[i]) begin
          mem[addr_i][i*NIBBLE_W +: NIBBLE_W] <= wdata_i[i*NIBBLE_W +: NIBBLE_W];
        end
      end
    end
  end

  // Read register holds its value between read strobes.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem[addr_i];
  end

  // Read data register, cleared by reset.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  always_comb rdata_o = rdata_q;

endmodule

// File: rtl/vram_responder.sv
// Slave end of the graphite VRAM bus: captures a request, waits LATENCY
// cycles, performs the access on an on-chip RAM and pulses ack for one cycle.
// Optional feature macro: VRAM_SWAP_EN (two memory pages selected by page_o,
// toggled by swap_i pulses).
module vram_responder
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_ni,
  input  logic                   vram_sel_i,
  input  logic                   vram_wr_i,
  input  logic [VRAM_MASK_W-1:0] vram_mask_i,
  input  logic [31:0]            vram_addr_i,
  input  logic [VRAM_DATA_W-1:0] vram_data_in_i,
  output logic [VRAM_DATA_W-1:0] vram_data_out_o,
  output logic                   vram_ack_o
`ifdef VRAM_SWAP_EN
  ,
  input  logic                   swap_i,
  output logic                   page_o
`endif
);

  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  vram_resp_state_t state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic [VRAM_MASK_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [VRAM_DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]      req_addr;
  logic                   mem_we, mem_re;
  logic                   unused_addr;

`ifdef VRAM_SWAP_EN
  logic page_q, page_d;
  logic pend_q, pend_d;

  // Effective address uses the page as it stood before this edge's swap.
  always_comb begin
    req_addr    = {page_q, vram_addr_i[ADDR_W-2:0]};
    unused_addr = ^{vram_addr_i[31:ADDR_W-1]};
  end

  // Swap in IDLE toggles at once; swaps while busy coalesce into one
  // toggle applied on the ACK->IDLE edge.
  always_comb begin
    page_d = page_q;
    pend_d = pend_q;
    unique case (state_q)
      IDLE: if (swap_i) page_d = ~page_q;
      ACK: begin
        if (pend_q || swap_i) page_d = ~page_q;
        pend_d = 1'b0;
      end
      default: if (swap_i) pend_d = 1'b1;
    endcase
  end

  // Page and pending-swap registers.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      page_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      page_q <= page_d;
      pend_q <= pend_d;
    end
  end

  always_comb page_o = page_q;
`else
  // Flat memory: high address bits alias by design.
  always_comb begin
    req_addr    = vram_addr_i[ADDR_W-1:0];
    unused_addr = ^{vram_addr_i[31:ADDR_W]};
  end
`endif

  // Next-state, capture and memory strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vram_sel_i) begin
          wr_d    = vram_wr_i;
          mask_d  = vram_mask_i;
          addr_d  = req_addr;
          data_d  = vram_data_in_i;
          cnt_d   = LAT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          mem_we  = wr_q;
          mem_re  = ~wr_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latency counter and captured request fields.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb vram_ack_o = (state_q == ACK);

  vram_bram #(
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk     (clk),
    .rst_ni  (reset_ni),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .mask_i  (mask_q),
    .addr_i  (addr_q),
    .wdata_i (data_q),
    .rdata_o (vram_data_out_o)
  );

endmodule

// File: tb/tb_vram_responder.sv
// Directed bench for vram_responder (LATENCY=2, ADDR_W=14).
module tb_vram_responder;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        vram_sel_i = 1'b0;
  logic        vram_wr_i = 1'b0;
  logic [3:0]  vram_mask_i = '0;
  logic [31:0] vram_addr_i = '0;
  logic [15:0] vram_data_in_i = '0;
  logic [15:0] vram_data_out_o;
  logic        vram_ack_o;
`ifdef VRAM_SWAP_EN
  logic        swap_i = 1'b0;
  logic        page_o;
`endif

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (vram_ack_o === 1'b1) ack_cnt++;

  vram_responder #(
    .ADDR_W  (14),
    .LATENCY (2)
  ) dut (
    .clk             (clk),
    .reset_ni        (reset_ni),
    .vram_sel_i      (vram_sel_i),
    .vram_wr_i       (vram_wr_i),
    .vram_mask_i     (vram_mask_i),
    .vram_addr_i     (vram_addr_i),
    .vram_data_in_i  (vram_data_in_i),
    .vram_data_out_o (vram_data_out_o),
    .vram_ack_o      (vram_ack_o)
`ifdef VRAM_SWAP_EN
    ,
    .swap_i          (swap_i),
    .page_o          (page_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; returns read data and negedges from drive to ack.
  task automatic req(input logic wr, input logic [3:0] m, input logic [31:0] a,
                     input logic [15:0] d, output logic [15:0] rd, output int n);
    @(negedge clk);
    vram_sel_i = 1'b1; vram_wr_i = wr; vram_mask_i = m;
    vram_addr_i = a; vram_data_in_i = d;
    n = 0;
    do begin @(negedge clk); n++; end while (vram_ack_o !== 1'b1 && n < 20);
    rd = vram_data_out_o;
    vram_sel_i = 1'b0;
    @(negedge clk);
    check("ack_single", {31'd0, vram_ack_o}, 32'd0);
  endtask

  logic [15:0] rd;
  int          n;
  int          snap;
  logic [31:0] b2b_addr [8] = '{32'h4, 32'h7, 32'h10, 32'h4, 32'h7, 32'h10, 32'h4, 32'h7};
  logic [15:0] b2b_exp  [8] = '{16'hA2C4, 16'h5555, 16'h7777, 16'hA2C4,
                                16'h5555, 16'h7777, 16'hA2C4, 16'h5555};

  initial begin
    // Outputs during initial reset
    #3;
    check("rst_ack", {31'd0, vram_ack_o}, 32'd0);
    check("rst_dout", {16'd0, vram_data_out_o}, 32'd0);
`ifdef VRAM_SWAP_EN
    check("rst_page", {31'd0, page_o}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;

    // Full write then read, latency 3 negedges from drive (ack after edge t0+2)
    req(1'b1, 4'hF, 32'h4, 16'hABCD, rd, n);
    check("wr_lat", n, 3);
    req(1'b0, 4'h0, 32'h4, 16'h0, rd, n);
    check("rd_lat", n, 3);
    check("rd_abcd", {16'd0, rd}, 32'h0000ABCD);

    // Partial mask write; data_out holds last read value across writes
    req(1'b1, 4'b0101, 32'h4, 16'h1234, rd, n);
    check("dout_hold", {16'd0, vram_data_out_o}, 32'h0000ABCD);
    req(1'b0, 4'h0, 32'h4, 16'h0, rd, n);
    check("rd_partial", {16'd0, rd}, 32'h0000A2C4);

    // Mask 0 write still acks, no change
    req(1'b1, 4'h0, 32'h4, 16'hFFFF, rd, n);
    check("mask0_lat", n, 3);
    req(1'b0, 4'h0, 32'h4, 16'h0, rd, n);
    check("mask0_rd", {16'd0, rd}, 32'h0000A2C4);

    // Address wrap
    req(1'b1, 4'hF, 32'h0000_4007, 16'h5555, rd, n);
    req(1'b0, 4'h0, 32'h0000_0007, 16'h0, rd, n);
    check("wrap_rd", {16'd0, rd}, 32'h00005555);

    // Reset in WAIT of a write discards it
    req(1'b1, 4'hF, 32'h10, 16'h7777, rd, n);
    req(1'b0, 4'h0, 32'h10, 16'h0, rd, n);
    check("rd_7777", {16'd0, rd}, 32'h00007777);
    @(negedge clk);
    vram_sel_i = 1'b1; vram_wr_i = 1'b1; vram_mask_i = 4'hF;
    vram_addr_i = 32'h10; vram_data_in_i = 16'h9999;
    @(negedge clk);
    #1;
    snap = ack_cnt;
    reset_ni = 1'b0;
    vram_sel_i = 1'b0;
    #1;
    check("rstw_ack", {31'd0, vram_ack_o}, 32'd0);
    check("rstw_dout", {16'd0, vram_data_out_o}, 32'd0);
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rstw_noack", ack_cnt, snap);
    req(1'b0, 4'h0, 32'h10, 16'h0, rd, n);
    check("rstw_rd", {16'd0, rd}, 32'h00007777);

    // Back-to-back reads with sel held high
    @(negedge clk);
    vram_sel_i = 1'b1; vram_wr_i = 1'b0; vram_addr_i = b2b_addr[0];
    for (int k = 0; k < 8; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (vram_ack_o !== 1'b1 && n < 20);
      check("b2b_gap", n, (k == 0) ? 3 : 4);
      check("b2b_data", {16'd0, vram_data_out_o}, {16'd0, b2b_exp[k]});
      if (k < 7) vram_addr_i = b2b_addr[k+1];
    end
    vram_sel_i = 1'b0;
    @(negedge clk);
    check("b2b_end", {31'd0, vram_ack_o}, 32'd0);

`ifdef VRAM_SWAP_EN
    // Swap pulse during WAIT of a write: write stays on page 0, page toggles entering IDLE
    req(1'b1, 4'hF, 32'h1, 16'h1111, rd, n);
    @(negedge clk);
    vram_sel_i = 1'b1; vram_wr_i = 1'b1; vram_mask_i = 4'hF;
    vram_addr_i = 32'h1; vram_data_in_i = 16'h2222;
    @(negedge clk);
    swap_i = 1'b1;
    @(negedge clk);
    swap_i = 1'b0;
    n = 0;
    while (vram_ack_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vram_sel_i = 1'b0;
    check("swap_pend", {31'd0, page_o}, 32'd0);
    @(negedge clk);
    check("swap_page1", {31'd0, page_o}, 32'd1);
    req(1'b0, 4'h0, 32'h1, 16'h0, rd, n);
    check("swap_rd_ne", {31'd0, (rd !== 16'h2222)}, 32'd1);
    @(negedge clk);
    swap_i = 1'b1;
    @(negedge clk);
    swap_i = 1'b0;
    check("swap_page0", {31'd0, page_o}, 32'd0);
    req(1'b0, 4'h0, 32'h1, 16'h0, rd, n);
    check("swap_rd_p0", {16'd0, rd}, 32'h00002222);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
